// File: rtl/tpm_buf_pkg.sv
// Shared types and helpers for the TPM command/response buffer arbiter.
// Holds the arbiter FSM states, the byte-lane write-enable decode and the default rejected-read fill byte.
package tpm_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_RD,
    ST_WB_ACK,
    ST_DP_RD,
    ST_DP_ACK
  } state_e;

  localparam logic [7:0] DP_FILL_DEF = 8'hFF;

  // Little-endian lane decode: byte address bits [1:0] select bits [8n+7:8n].
  function automatic logic [3:0] lane_wen(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/tpm_buf_lane_mux.sv
// Byte-lane steering between the 8-bit data-provider port and the 32-bit buffer RAM.
// Write bytes are replicated on every lane (the write enable picks one); reads select one lane.
module tpm_buf_lane_mux (
  input  logic [1:0]  lane_i,
  input  logic [7:0]  wr_byte_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] wr_word_o,
  output logic [7:0]  rd_byte_o
);

  always_comb begin
    wr_word_o = {4{wr_byte_i}};
    case (lane_i)
      2'd0:    rd_byte_o = rd_word_i[7:0];
      2'd1:    rd_byte_o = rd_word_i[15:8];
      2'd2:    rd_byte_o = rd_word_i[23:16];
      default: rd_byte_o = rd_word_i[31:24];
    endcase
  end

endmodule

// File: rtl/tpm_buf_arbiter.sv
// Single-clock arbiter sharing the TPM buffer RAM between the CPU Wishbone port and the host data provider.
// Ownership follows exec_i; accesses from the non-owner are answered locally and never reach the RAM.
module tpm_buf_arbiter
  import tpm_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter bit          STRICT_OWNER = 1'b1,
  parameter int unsigned WB_TIMEOUT   = 255,
  parameter logic [7:0]  DP_FILL      = DP_FILL_DEF
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  exec_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [ADDR_WIDTH-3:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic                  dp_req_i,
  input  logic                  dp_we_i,
  input  logic [ADDR_WIDTH-1:0] dp_addr_i,
  input  logic [7:0]            dp_dat_i,
  output logic [7:0]            dp_dat_o,
  output logic                  dp_ack_o,
  output logic [ADDR_WIDTH-3:0] ram_a_o,
  output logic [31:0]           ram_wd_o,
  output logic [3:0]            ram_wen_o,
  input  logic [31:0]           ram_rd_i
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(WB_TIMEOUT);

  state_e      state_q, state_d;
  logic        wb_ack_q, wb_ack_d;
  logic        wb_err_q, wb_err_d;
  logic        dp_ack_q, dp_ack_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [7:0]  dp_dat_q, dp_dat_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        wb_req, idle;
  logic        wb_grant, dp_grant;
  logic        wb_bad, dp_bad;
  logic [31:0] dp_wr_word;
  logic [7:0]  dp_rd_byte;

  // Requests already answered (ack/err high) or still in flight are not granted or rejected again,
  // so a level request held into its own ack cycle never produces a second response.
  always_comb begin
    wb_req   = wb_cyc_i & wb_stb_i;
    idle     = rstn_i & (state_q == ST_IDLE);
    wb_grant = idle & wb_req & exec_i & ~wb_err_q;
    dp_grant = idle & dp_req_i & ~exec_i & ~dp_ack_q;
    wb_bad   = wb_req & ~exec_i & ~wb_ack_q & ~wb_err_q & (state_q != ST_WB_RD);
    dp_bad   = dp_req_i & exec_i & ~dp_ack_q & (state_q != ST_DP_RD);
  end

  tpm_buf_lane_mux u_lane_mux (
    .lane_i    (lane_q),
    .wr_byte_i (dp_dat_i),
    .rd_word_i (ram_rd_i),
    .wr_word_o (dp_wr_word),
    .rd_byte_o (dp_rd_byte)
  );

  // RAM strobes come straight from the grant decode so the access issues in the grant cycle;
  // reset masks them through idle.
  always_comb begin
    ram_a_o   = '0;
    ram_wd_o  = '0;
    ram_wen_o = '0;
    if (wb_grant) begin
      ram_a_o = wb_adr_i;
      if (wb_we_i) begin
        ram_wen_o = wb_sel_i;
        ram_wd_o  = wb_dat_i;
      end
    end else if (dp_grant) begin
      ram_a_o = dp_addr_i[ADDR_WIDTH-1:2];
      if (dp_we_i) begin
        ram_wen_o = lane_wen(dp_addr_i[1:0]);
        ram_wd_o  = dp_wr_word;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wb_ack_d = 1'b0;
    wb_err_d = 1'b0;
    dp_ack_d = 1'b0;
    wb_dat_d = wb_dat_q;
    dp_dat_d = dp_dat_q;
    lane_d   = lane_q;
    tmo_d    = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (wb_grant) begin
          state_d  = wb_we_i ? ST_WB_ACK : ST_WB_RD;
          wb_ack_d = wb_we_i;
        end else if (dp_grant) begin
          lane_d   = dp_addr_i[1:0];
          state_d  = dp_we_i ? ST_DP_ACK : ST_DP_RD;
          dp_ack_d = dp_we_i;
        end
      end
      ST_WB_RD: begin
        wb_dat_d = ram_rd_i;
        wb_ack_d = 1'b1;
        state_d  = ST_WB_ACK;
      end
      ST_DP_RD: begin
        dp_dat_d = dp_rd_byte;
        dp_ack_d = 1'b1;
        state_d  = ST_DP_ACK;
      end
      ST_WB_ACK, ST_DP_ACK: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase

    if (dp_bad) begin
      dp_ack_d = 1'b1;
      if (!dp_we_i) dp_dat_d = DP_FILL;
    end

    // Stall counter runs only while a wrong-owner WB cycle is held; in strict mode it never advances.
    if (!wb_cyc_i || wb_grant || wb_err_q) begin
      tmo_d = '0;
    end else if (wb_bad) begin
      if (STRICT_OWNER || ((tmo_q + 8'd1) == TIMEOUT_LIM)) begin
        wb_err_d = 1'b1;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      wb_ack_q <= 1'b0;
      wb_err_q <= 1'b0;
      dp_ack_q <= 1'b0;
      wb_dat_q <= '0;
      dp_dat_q <= '0;
      lane_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      wb_ack_q <= wb_ack_d;
      wb_err_q <= wb_err_d;
      dp_ack_q <= dp_ack_d;
      wb_dat_q <= wb_dat_d;
      dp_dat_q <= dp_dat_d;
      lane_q   <= lane_d;
      tmo_q    <= tmo_d;
    end
  end

  assign wb_ack_o = wb_ack_q;
  assign wb_err_o = wb_err_q;
  assign wb_dat_o = wb_dat_q;
  assign dp_ack_o = dp_ack_q;
  assign dp_dat_o = dp_dat_q;

endmodule

// File: tb/tb_tpm_buf_arbiter.sv
// Scoreboard bench for tpm_buf_arbiter: drivers push expected responses, a negedge monitor pops and compares.
// A second instance with relaxed ownership and a short timeout covers the stall-to-error path.
module tb_tpm_buf_arbiter;

  typedef struct {
    bit          err;
    int unsigned lat;
    bit          chk;
    logic [31:0] dat;
    int unsigned issue;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // main DUT signals
  logic        exec = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic [8:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        dp_req = 1'b0, dp_we = 1'b0;
  logic [10:0] dp_addr = '0;
  logic [7:0]  dp_dat = '0;
  logic [7:0]  dp_dat_o;
  logic        dp_ack_o;
  logic [8:0]  ram_a;
  logic [31:0] ram_wd;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rd;

  // timeout DUT signals
  logic        t_exec = 1'b0, t_cyc = 1'b0, t_stb = 1'b0, t_we = 1'b0;
  logic [3:0]  t_sel = '0;
  logic [8:0]  t_adr = '0;
  logic [31:0] t_dat = '0;
  logic [31:0] t_dat_o;
  logic        t_ack, t_err;
  logic        t_dp_req = 1'b0, t_dp_we = 1'b0;
  logic [10:0] t_dp_addr = '0;
  logic [7:0]  t_dp_dat = '0;
  logic [7:0]  t_dp_dat_o;
  logic        t_dp_ack;
  logic [8:0]  t_ram_a;
  logic [31:0] t_ram_wd;
  logic [3:0]  t_ram_wen;
  logic [31:0] t_ram_rd = '0;

  tpm_buf_arbiter dut (
    .clk_i(clk), .rstn_i(rstn), .exec_i(exec),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .dp_req_i(dp_req), .dp_we_i(dp_we), .dp_addr_i(dp_addr), .dp_dat_i(dp_dat),
    .dp_dat_o(dp_dat_o), .dp_ack_o(dp_ack_o),
    .ram_a_o(ram_a), .ram_wd_o(ram_wd), .ram_wen_o(ram_wen), .ram_rd_i(ram_rd)
  );

  tpm_buf_arbiter #(.STRICT_OWNER(1'b0), .WB_TIMEOUT(4)) dut_to (
    .clk_i(clk), .rstn_i(rstn), .exec_i(t_exec),
    .wb_cyc_i(t_cyc), .wb_stb_i(t_stb), .wb_we_i(t_we), .wb_sel_i(t_sel),
    .wb_adr_i(t_adr), .wb_dat_i(t_dat), .wb_dat_o(t_dat_o), .wb_ack_o(t_ack), .wb_err_o(t_err),
    .dp_req_i(t_dp_req), .dp_we_i(t_dp_we), .dp_addr_i(t_dp_addr), .dp_dat_i(t_dp_dat),
    .dp_dat_o(t_dp_dat_o), .dp_ack_o(t_dp_ack),
    .ram_a_o(t_ram_a), .ram_wd_o(t_ram_wd), .ram_wen_o(t_ram_wen), .ram_rd_i(t_ram_rd)
  );

  // buffer RAM with one-cycle synchronous read
  logic [31:0] ram [512];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) ram[ram_a][8*b +: 8] <= ram_wd[8*b +: 8];
    ram_rd <= ram[ram_a];
  end

  // reference buffer contents, updated when a request is issued
  logic [31:0] ref_mem [512];
  exp_t wb_q[$];
  exp_t dp_q[$];
  exp_t to_q[$];
  bit   chk_no_wen = 1'b0;
  bit   t_no_wen   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    n_chk++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_wb_ack"},  32'(wb_ack_o), 32'd0);
    check({tag, "_wb_err"},  32'(wb_err_o), 32'd0);
    check({tag, "_dp_ack"},  32'(dp_ack_o), 32'd0);
    check({tag, "_wb_dat"},  wb_dat_o, 32'd0);
    check({tag, "_dp_dat"},  32'(dp_dat_o), 32'd0);
    check({tag, "_ram_wen"}, 32'(ram_wen), 32'd0);
    check({tag, "_ram_a"},   32'(ram_a), 32'd0);
    check({tag, "_ram_wd"},  ram_wd, 32'd0);
  endtask

  function automatic logic [7:0] ref_byte(input logic [10:0] a);
    logic [31:0] w;
    int l;
    w = ref_mem[a[10:2]];
    l = int'(a[1:0]);
    return w[8*l +: 8];
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn) begin
      if (chk_no_wen) check("no_ram_write", 32'(ram_wen), 32'd0);
      if (t_no_wen)   check("t_no_ram_write", 32'(t_ram_wen), 32'd0);
      if (wb_ack_o || wb_err_o) begin
        check("wb_ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'd0);
        if (wb_q.size() == 0) report_fail("wb_unexpected", "got ack/err, required none");
        else begin
          e = wb_q.pop_front();
          check("wb_kind_err", 32'(wb_err_o), 32'(e.err));
          check("wb_latency", cyc_cnt - e.issue, e.lat);
          if (e.chk) check("wb_rdata", wb_dat_o, e.dat);
        end
      end
      if (dp_ack_o) begin
        if (dp_q.size() == 0) report_fail("dp_unexpected", "got ack, required none");
        else begin
          e = dp_q.pop_front();
          check("dp_latency", cyc_cnt - e.issue, e.lat);
          if (e.chk) check("dp_rdata", 32'(dp_dat_o), e.dat);
        end
      end
      if (t_ack || t_err) begin
        check("t_ack_err_excl", 32'(t_ack & t_err), 32'd0);
        if (to_q.size() == 0) report_fail("t_unexpected", "got ack/err, required none");
        else begin
          e = to_q.pop_front();
          check("t_kind_err", 32'(t_err), 32'(e.err));
          check("t_latency", cyc_cnt - e.issue, e.lat);
        end
      end
    end
  end

  task automatic do_wb(input bit ex, input bit we, input logic [8:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input bit drop_exec);
    exp_t e;
    bit done;
    @(posedge clk); #1;
    exec = ex; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat = dat;
    e.issue = cyc_cnt;
    e.dat   = '0;
    if (ex) begin
      e.err = 1'b0;
      e.lat = we ? 1 : 2;
      e.chk = !we;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[adr][8*b +: 8] = dat[8*b +: 8];
      end else begin
        e.dat = ref_mem[adr];
      end
    end else begin
      e.err = 1'b1;
      e.lat = 1;
      e.chk = 1'b0;
      chk_no_wen = 1'b1;
    end
    wb_q.push_back(e);
    if (drop_exec) begin
      @(posedge clk); #1;
      exec = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      done = wb_ack_o | wb_err_o;
    end
    if (!done) report_fail("wb_wait", "no ack/err within 16 cycles, required one");
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; chk_no_wen = 1'b0;
  endtask

  task automatic do_dp(input bit ex, input bit we, input logic [10:0] a, input logic [7:0] d);
    exp_t e;
    bit done;
    int l;
    @(posedge clk); #1;
    exec = ex; dp_req = 1'b1; dp_we = we; dp_addr = a; dp_dat = d;
    e.issue = cyc_cnt;
    e.err   = 1'b0;
    e.chk   = !we;
    e.dat   = '0;
    if (!ex) begin
      e.lat = we ? 1 : 2;
      if (we) begin
        l = int'(a[1:0]);
        ref_mem[a[10:2]][8*l +: 8] = d;
      end else begin
        e.dat = {24'h0, ref_byte(a)};
      end
    end else begin
      e.lat = 1;
      e.dat = 32'h0000_00FF;
      chk_no_wen = 1'b1;
    end
    dp_q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      done = dp_ack_o;
    end
    if (!done) report_fail("dp_wait", "no ack within 16 cycles, required one");
    @(posedge clk); #1;
    dp_req = 1'b0; chk_no_wen = 1'b0;
  endtask

  task automatic t_stall(input int unsigned cycles_before_drop);
    exp_t e;
    bit done;
    @(posedge clk); #1;
    t_exec = 1'b0; t_we = 1'b0; t_cyc = 1'b1; t_stb = 1'b1; t_no_wen = 1'b1;
    if (cycles_before_drop != 0) begin
      repeat (cycles_before_drop) @(posedge clk);
      #1;
      t_cyc = 1'b0; t_stb = 1'b0;
      @(posedge clk); #1;
      t_cyc = 1'b1; t_stb = 1'b1;
    end
    e.issue = cyc_cnt; e.err = 1'b1; e.lat = 4; e.chk = 1'b0; e.dat = '0;
    to_q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      done = t_err | t_ack;
    end
    if (!done) report_fail("t_wait", "no err within 12 cycles, required one");
    @(posedge clk); #1;
    t_cyc = 1'b0; t_stb = 1'b0; t_no_wen = 1'b0;
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin : stim
    exp_t e;
    int unsigned kind;
    bit ex;
    bit done;
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int w = 0; w < 16; w++) do_wb(1'b1, 1'b1, 9'(w), 4'hF, $urandom, 1'b0);

    do_wb(1'b1, 1'b1, 9'd5, 4'hF, 32'hDEADBEEF, 1'b0);
    do_wb(1'b1, 1'b0, 9'd5, 4'h0, 32'h0, 1'b0);

    do_dp(1'b0, 1'b1, 11'd0, 8'h11);
    do_dp(1'b0, 1'b1, 11'd1, 8'h22);
    do_dp(1'b0, 1'b1, 11'd2, 8'h33);
    do_dp(1'b0, 1'b1, 11'd3, 8'h44);
    do_wb(1'b1, 1'b0, 9'd0, 4'h0, 32'h0, 1'b0);

    do_wb(1'b0, 1'b0, 9'd3, 4'h0, 32'h0, 1'b0);

    do_dp(1'b1, 1'b0, 11'd7, 8'h00);
    do_dp(1'b1, 1'b1, 11'd5, 8'hAB);
    do_wb(1'b1, 1'b0, 9'd1, 4'h0, 32'h0, 1'b0);

    do_wb(1'b1, 1'b0, 9'd5, 4'h0, 32'h0, 1'b1);
    do_wb(1'b0, 1'b0, 9'd5, 4'h0, 32'h0, 1'b0);

    do_wb(1'b1, 1'b1, 9'd5, 4'h0, 32'h12345678, 1'b0);
    do_dp(1'b0, 1'b0, 11'd22, 8'h00);
    do_wb(1'b1, 1'b0, 9'd5, 4'h0, 32'h0, 1'b0);

    // reset while a read sits in WB_RD
    @(posedge clk); #1;
    exec = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 9'd5;
    @(posedge clk); #1;
    rstn = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    do_wb(1'b1, 1'b1, 9'd9, 4'hF, 32'hCAFEF00D, 1'b0);
    do_wb(1'b1, 1'b0, 9'd9, 4'h0, 32'h0, 1'b0);

    for (int n = 0; n < 160; n++) begin
      kind = $urandom_range(0, 3);
      ex   = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      case (kind)
        0: do_wb(ex, 1'b1, 9'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, 1'b0);
        1: do_wb(ex, 1'b0, 9'($urandom_range(0, 15)), 4'h0, 32'h0, 1'b0);
        2: do_dp(ex, 1'b1, 11'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
        default: do_dp(ex, 1'b0, 11'($urandom_range(0, 63)), 8'h00);
      endcase
    end

    t_stall(0);
    t_stall(2);
    @(posedge clk); #1;
    t_exec = 1'b1; t_we = 1'b1; t_sel = 4'hF; t_cyc = 1'b1; t_stb = 1'b1;
    e.issue = cyc_cnt; e.err = 1'b0; e.lat = 1; e.chk = 1'b0; e.dat = '0;
    to_q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      done = t_ack | t_err;
    end
    if (!done) report_fail("t_write_wait", "no ack within 12 cycles, required one");
    @(posedge clk); #1;
    t_cyc = 1'b0; t_stb = 1'b0;

    repeat (4) @(posedge clk);
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("dp_queue_drained", 32'(dp_q.size()), 32'd0);
    check("t_queue_drained",  32'(to_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
